// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction memory request/ack,
// redirect input and the decode-facing valid/ready stream.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, one-outstanding imem request,
// prefetch FIFO toward decode, and redirect with stale-ack drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_DROP  = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   stale_q, stale_d;
  logic [31:0]   tgt_q, tgt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  ent_t          mem_q [FIFO_DEPTH];

  logic        req, fire, redir, push, pop;
  logic [31:0] rpc;
  ent_t        head;

  assign rpc   = bus.redirect_pc & 32'hFFFF_FFFC;
  assign redir = bus.redirect_valid;
  assign req   = !rst && (state_q == S_DROP || cnt_q < FULL);
  assign fire  = req && bus.imem_ack;
  assign push  = fire && state_q == S_FETCH && !redir;
  assign pop   = bus.out_valid && bus.out_ready;
  assign head  = mem_q[rptr_q];

  assign bus.imem_req  = req;
  assign bus.imem_addr = (state_q == S_DROP) ? stale_q : pc_q;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      S_FETCH: begin
        // A pending unacked request must be drained before retargeting
        if (redir && req && !bus.imem_ack) begin
          stale_d = pc_q;
          tgt_d   = rpc;
          state_d = S_DROP;
        end else if (redir) begin
          pc_d = rpc;
        end else if (fire) begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_DROP: begin
        if (fire) begin
          state_d = S_FETCH;
          pc_d    = redir ? rpc : tgt_q;
        end else if (redir) begin
          tgt_d = rpc;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (redir) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      stale_q <= '0;
      tgt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      tgt_q   <= tgt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.imem_rdata, pc_q};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && cnt_q == FULL));
      assert (!(pop && cnt_q == '0));
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: latency-programmable imem model,
// expected out_pc queue drained by a negedge monitor.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int wcnt;
  int acks;
  int n80   = 0;
  bit allow = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] e_pc;

  function automatic logic [31:0] fimg(input logic [31:0] a);
    return (a ^ 32'h3C5A_0000) + 32'h0000_1111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: acks after lat wait cycles, reset with the DUT
  assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
  assign bus.imem_rdata = bus.imem_ack ? fimg(bus.imem_addr)
                                       : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 0;
      acks <= 0;
    end else if (bus.imem_req && bus.imem_ack) begin
      wcnt <= 0;
      acks <= acks + 1;
    end else if (bus.imem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    bus.out_ready = allow && (exp_q.size() != 0);
  end

  always begin
    @(negedge clk);
    if (bus.imem_req && bus.imem_addr == 32'h80) n80++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexp_out", {31'b0, bus.out_valid}, 32'h0);
      end else begin
        e_pc = exp_q.pop_front();
        chk("out_pc", bus.out_pc, e_pc);
        chk("out_instr", bus.out_instr, fimg(e_pc));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    allow = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    tick();
    tick();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect_pc    = pc;
    bus.redirect_valid = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    exp_q.delete();
    chk("flush_valid", {31'b0, bus.out_valid}, 32'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.imem_req) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int n;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst = 1'b1;

    // Zero-wait streaming from reset
    lat = 0;
    do_reset();
    push_run(32'h0, 8);
    allow = 1'b1;
    rst = 1'b0;
    #1;
    chk("t1_req0", {31'b0, bus.imem_req}, 32'h1);
    chk("t1_addr0", bus.imem_addr, 32'h0);
    tick();
    chk("t1_addr4", bus.imem_addr, 32'h4);
    chk("t1_lat", {31'b0, bus.out_valid}, 32'h1);
    tick();
    chk("t1_addr8", bus.imem_addr, 32'h8);
    chk("t1_v2", {31'b0, bus.out_valid}, 32'h1);
    tick();
    chk("t1_addrC", bus.imem_addr, 32'hC);
    chk("t1_v3", {31'b0, bus.out_valid}, 32'h1);
    wait_idle("t1_idle");

    // Backpressure: fill, stall, release
    do_reset();
    rst = 1'b0;
    repeat (10) tick();
    chk("t2_acks", 32'(acks), 32'd4);
    chk("t2_req_lo", {31'b0, bus.imem_req}, 32'h0);
    chk("t2_addr", bus.imem_addr, 32'h10);
    push_run(32'h0, 8);
    allow = 1'b1;
    tick();
    chk("t2_req_still_lo", {31'b0, bus.imem_req}, 32'h0);
    chk("t2_head", bus.out_pc, 32'h0);
    tick();
    chk("t2_req_rise", {31'b0, bus.imem_req}, 32'h1);
    chk("t2_addr_hold", bus.imem_addr, 32'h10);
    wait_idle("t2_idle");

    // Redirect while a 3-cycle request is pending
    lat = 3;
    do_reset();
    push_run(32'h0, 2);
    allow = 1'b1;
    rst = 1'b0;
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == 32'h8) && n < 50) begin
      tick();
      n++;
    end
    chk("t3_req8", bus.imem_addr, 32'h8);
    tick();
    do_redirect(32'h40);
    chk("t3_drop_addr", bus.imem_addr, 32'h8);
    chk("t3_drop_req", {31'b0, bus.imem_req}, 32'h1);
    push_run(32'h40, 4);
    n = 0;
    while (bus.imem_addr == 32'h8 && n < 50) begin
      tick();
      n++;
    end
    chk("t3_next_addr", bus.imem_addr, 32'h40);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t3_first_pc", bus.out_pc, 32'h40);
    wait_idle("t3_idle");

    // Redirect on the same edge as an ack; low bits ignored
    do_redirect(32'h20);
    chk("t4_addr20", bus.imem_addr, 32'h20);
    n = 0;
    while (!bus.imem_ack && n < 50) begin
      tick();
      n++;
    end
    chk("t4_ack20", {31'b0, bus.imem_ack}, 32'h1);
    do_redirect(32'h103);
    chk("t4_addr100", bus.imem_addr, 32'h100);
    chk("t4_req", {31'b0, bus.imem_req}, 32'h1);
    push_run(32'h100, 4);
    wait_idle("t4_idle");

    // Two redirects inside one DROP window
    lat = 5;
    do_redirect(32'h60);
    chk("t5_addr60", bus.imem_addr, 32'h60);
    do_redirect(32'h80);
    chk("t5_stale", bus.imem_addr, 32'h60);
    do_redirect(32'h200);
    push_run(32'h200, 4);
    n = 0;
    while (bus.imem_addr == 32'h60 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_next_addr", bus.imem_addr, 32'h200);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t5_first_pc", bus.out_pc, 32'h200);
    chk("t5_no80", 32'(n80), 32'h0);
    wait_idle("t5_idle");

    // Wrap of the fetch PC, then reset mid-request
    lat = 0;
    do_redirect(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    wait_idle("t6_wrap_idle");
    lat = 5;
    do_redirect(32'h400);
    chk("t6_pend", {31'b0, bus.imem_req}, 32'h1);
    tick();
    rst = 1'b1;
    allow = 1'b0;
    #1;
    chk("t6_rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("t6_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    tick();
    lat = 0;
    exp_q.delete();
    push_run(32'h0, 2);
    allow = 1'b1;
    rst = 1'b0;
    #1;
    chk("t6_req", {31'b0, bus.imem_req}, 32'h1);
    chk("t6_addr", bus.imem_addr, 32'h0);
    wait_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
